mux_pipe_reg: RTL

Parametrised N-to-1 source selector with a registered, back-pressurable output. It picks one of NUM_SRC WIDTH-bit sources per transfer and holds the result in a two-entry elastic stage (main register plus skid register) under a valid/ready handshake. It sits between pipeline stages of the RISC-V core wherever operand or PC selection must also absorb a downstream stall, for example at the EX operand input or the next-PC source. Full throughput with a registered `ready_o`, order preserved, flushable.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_nto1.sv | 26 ++
 rtl/mux_pipe_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-to-1 source selector.
package mux_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned MaxWidth     = 1024;

    // Occupancy of the main/skid pair
    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } occ_e;

    // Word substituted when the select is out of range; callers size-cast to WIDTH
    function automatic logic [MaxWidth-1:0] invalid_word();
        return '0;
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N-to-1 selector over a flattened source bus, flagging out-of-range selects.
module mux_nto1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     sel_err
);

    always_comb begin
        data_o  = WIDTH'(invalid_word());
        sel_err = 1'b1;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (32'(sel_i) == k) begin
                data_o  = src_i[k*WIDTH +: WIDTH];
                sel_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_pipe_reg.sv
// Source selector feeding a two-entry elastic stage (main + skid) with a registered ready.
module mux_pipe_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_SRC*WIDTH-1:0] src_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     err_o
);

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             drain;

    mux_nto1 #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .src_i   (src_i),
        .sel_i   (sel_i),
        .data_o  (sel_data),
        .sel_err (sel_err)
    );

    assign accept = valid_i && ready_q;
    assign drain  = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = sel_data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        main_d = sel_data;
                    end else if (accept) begin
                        skid_d  = sel_data;
                        state_d = StTwo;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // ready_q is low here, so no accept can coincide with the drain
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        ready_d = (state_d != StTwo);
        err_d   = accept && sel_err && !flush_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (state_q != StEmpty);
    assign data_o  = main_q;
    assign err_o   = err_q;

endmodule
